// File: rtl/gate_seq_if.sv
// Handshake and gate-result bundle between gate_vector_sequencer and the
// two-input gate block it exercises.
interface gate_seq_if;
  logic       start;
  logic       and_in;
  logic       or_in;
  logic       not_in;
  logic       nand_in;
  logic       nor_in;
  logic       xor_in;
  logic       xnor_in;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic [1:0] vec_idx;
  logic [2:0] err_count;
  logic [3:0] fail_mask;
  logic       pass;

  modport master (
    input  start, and_in, or_in, not_in, nand_in, nor_in, xor_in, xnor_in,
    output a, b, busy, done, vec_idx, err_count, fail_mask, pass
  );

  modport slave (
    output start, and_in, or_in, not_in, nand_in, nor_in, xor_in, xnor_in,
    input  a, b, busy, done, vec_idx, err_count, fail_mask, pass
  );
endinterface

// File: rtl/gate_vector_sequencer.sv
// Steps {a,b} through 00/01/10/11, holding each HOLD_CYCLES cycles, and grades
// the gate outputs at the end of each hold. Define GATE_SEQ_CHECK_EN for checking.
module gate_vector_sequencer #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  gate_seq_if.master bus
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic          a_q, b_q, busy_q, done_q, pass_q;
  logic [2:0]    err_q, err_d;
  logic [3:0]    mask_q, mask_d;

`ifdef GATE_SEQ_CHECK_EN
  function automatic logic gates_ok(input logic a, input logic b,
                                    input logic g_and, input logic g_or,
                                    input logic g_not, input logic g_nand,
                                    input logic g_nor, input logic g_xor,
                                    input logic g_xnor);
    return (g_and  == (a & b))    && (g_or   == (a | b))    &&
           (g_not  == ~a)         && (g_nand == ~(a & b))   &&
           (g_nor  == ~(a | b))   && (g_xor  == (a ^ b))    &&
           (g_xnor == ~(a ^ b));
  endfunction

  always_comb begin
    err_d  = err_q;
    mask_d = mask_q;
    if (!gates_ok(a_q, b_q, bus.and_in, bus.or_in, bus.not_in, bus.nand_in,
                  bus.nor_in, bus.xor_in, bus.xnor_in)) begin
      err_d         = err_q + 3'd1;
      mask_d[idx_q] = 1'b1;
    end
  end
`else
  // Stimulus-only build: gate outputs are ignored and every run reports pass.
  logic unused_gate_ins;
  assign unused_gate_ins = ^{bus.and_in, bus.or_in, bus.not_in, bus.nand_in,
                             bus.nor_in, bus.xor_in, bus.xnor_in, err_q, mask_q};
  assign err_d  = 3'd0;
  assign mask_d = 4'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      mask_q  <= 4'd0;
    end else begin
      case (state_q)
        // The DONE cycle also accepts start so runs can go back to back.
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          if (bus.start) begin
            state_q <= S_DRIVE;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            err_q   <= 3'd0;
            mask_q  <= 4'd0;
            pass_q  <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            err_q  <= err_d;
            mask_q <= mask_d;
            if (idx_q == 2'd3) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              idx_q   <= 2'd0;
              a_q     <= 1'b0;
              b_q     <= 1'b0;
              pass_q  <= (err_d == 3'd0);
            end else begin
              idx_q      <= idx_q + 2'd1;
              {a_q, b_q} <= idx_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.vec_idx   = idx_q;
  assign bus.err_count = err_q;
  assign bus.fail_mask = mask_q;
  assign bus.pass      = pass_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed checks of gate_vector_sequencer with H=10 and H=1 instances driving
// a behavioural gate block (with an optional stuck-at-0 xor output).
module tb_gate_vector_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic xor_fault;
  always #5 clk = ~clk;

  gate_seq_if if10();
  gate_seq_if if1();

  gate_vector_sequencer #(.HOLD_CYCLES(10)) dut10 (.clk(clk), .rst(rst), .bus(if10));
  gate_vector_sequencer #(.HOLD_CYCLES(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));

  assign if10.and_in  = if10.a & if10.b;
  assign if10.or_in   = if10.a | if10.b;
  assign if10.not_in  = ~if10.a;
  assign if10.nand_in = ~(if10.a & if10.b);
  assign if10.nor_in  = ~(if10.a | if10.b);
  assign if10.xor_in  = xor_fault ? 1'b0 : (if10.a ^ if10.b);
  assign if10.xnor_in = ~(if10.a ^ if10.b);

  assign if1.and_in  = if1.a & if1.b;
  assign if1.or_in   = if1.a | if1.b;
  assign if1.not_in  = ~if1.a;
  assign if1.nand_in = ~(if1.a & if1.b);
  assign if1.nor_in  = ~(if1.a | if1.b);
  assign if1.xor_in  = if1.a ^ if1.b;
  assign if1.xnor_in = ~(if1.a ^ if1.b);

`ifdef GATE_SEQ_CHECK_EN
  localparam logic [2:0] F_ERR  = 3'd2;
  localparam logic [3:0] F_MASK = 4'b0110;
  localparam logic       F_PASS = 1'b0;
`else
  localparam logic [2:0] F_ERR  = 3'd0;
  localparam logic [3:0] F_MASK = 4'b0000;
  localparam logic       F_PASS = 1'b1;
`endif

  int n_vec = 0;
  int n_bad = 0;
  string tag;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d expected %0d", tag, name, act, exp);
    end
  endtask

  typedef struct {
    int         k;
    logic       busy;
    logic       done;
    logic [1:0] idx;
  } chkpt_t;

  chkpt_t tbl[11];

  task automatic run_h10(input int extra_start, input int rst_at,
                         input logic [2:0] exp_err, input logic [3:0] exp_mask,
                         input logic exp_pass);
    int         ti = 0;
    int         dones = 0;
    logic [1:0] ix;
    for (int k = 0; k <= 45; k++) begin
      if10.start = (k == 0) || (k == extra_start);
      rst        = (k == rst_at);
      @(posedge clk); #1;
      if (if10.done) dones++;
      if (rst_at < 0) begin
        if (ti < 11 && tbl[ti].k == k) begin
          ix = tbl[ti].busy ? tbl[ti].idx : 2'd0;
          chk($sformatf("busy@%0d", k), 4'(if10.busy), 4'(tbl[ti].busy));
          chk($sformatf("done@%0d", k), 4'(if10.done), 4'(tbl[ti].done));
          chk($sformatf("idx@%0d", k),  4'(if10.vec_idx), 4'(tbl[ti].idx));
          chk($sformatf("a@%0d", k),    4'(if10.a), 4'(ix[1]));
          chk($sformatf("b@%0d", k),    4'(if10.b), 4'(ix[0]));
          ti++;
        end
        if (k == 0) begin
          chk("err_clr",  4'(if10.err_count), 4'd0);
          chk("mask_clr", if10.fail_mask, 4'd0);
          chk("pass_clr", 4'(if10.pass), 4'd0);
        end
        if (k == 40 || k == 45) begin
          chk($sformatf("err@%0d", k),  4'(if10.err_count), 4'(exp_err));
          chk($sformatf("mask@%0d", k), if10.fail_mask, exp_mask);
          chk($sformatf("pass@%0d", k), 4'(if10.pass), 4'(exp_pass));
        end
      end else if (k == rst_at) begin
        chk("rst_busy", 4'(if10.busy), 4'd0);
        chk("rst_done", 4'(if10.done), 4'd0);
        chk("rst_a",    4'(if10.a), 4'd0);
        chk("rst_b",    4'(if10.b), 4'd0);
        chk("rst_idx",  4'(if10.vec_idx), 4'd0);
        chk("rst_err",  4'(if10.err_count), 4'd0);
        chk("rst_mask", if10.fail_mask, 4'd0);
        chk("rst_pass", 4'(if10.pass), 4'd0);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    chk("done_pulses", 4'(dones), (rst_at < 0) ? 4'd1 : 4'd0);
  endtask

  initial begin
    rst        = 1'b1;
    xor_fault  = 1'b0;
    if10.start = 1'b0;
    if1.start  = 1'b0;

    tbl[0]  = '{k: 0,  busy: 1'b1, done: 1'b0, idx: 2'd0};
    tbl[1]  = '{k: 9,  busy: 1'b1, done: 1'b0, idx: 2'd0};
    tbl[2]  = '{k: 10, busy: 1'b1, done: 1'b0, idx: 2'd1};
    tbl[3]  = '{k: 15, busy: 1'b1, done: 1'b0, idx: 2'd1};
    tbl[4]  = '{k: 19, busy: 1'b1, done: 1'b0, idx: 2'd1};
    tbl[5]  = '{k: 20, busy: 1'b1, done: 1'b0, idx: 2'd2};
    tbl[6]  = '{k: 30, busy: 1'b1, done: 1'b0, idx: 2'd3};
    tbl[7]  = '{k: 39, busy: 1'b1, done: 1'b0, idx: 2'd3};
    tbl[8]  = '{k: 40, busy: 1'b0, done: 1'b1, idx: 2'd0};
    tbl[9]  = '{k: 41, busy: 1'b0, done: 1'b0, idx: 2'd0};
    tbl[10] = '{k: 45, busy: 1'b0, done: 1'b0, idx: 2'd0};

    // Reset, then 20 idle cycles with start low.
    tag = "idle";
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("busy", 4'(if10.busy), 4'd0);
      chk("done", 4'(if10.done), 4'd0);
      chk("a",    4'(if10.a), 4'd0);
      chk("b",    4'(if10.b), 4'd0);
      chk("err",  4'(if10.err_count), 4'd0);
      chk("mask", if10.fail_mask, 4'd0);
      chk("pass", 4'(if10.pass), 4'd0);
      chk("busy1", 4'(if1.busy), 4'd0);
      chk("done1", 4'(if1.done), 4'd0);
      @(negedge clk);
    end

    tag = "good_run";
    run_h10(15, -1, 3'd0, 4'd0, 1'b1);

    tag = "xor_fault";
    xor_fault = 1'b1;
    run_h10(-1, -1, F_ERR, F_MASK, F_PASS);
    xor_fault = 1'b0;

    tag = "rst_mid";
    run_h10(-1, 25, 3'd0, 4'd0, 1'b0);

    // H=1 with start held: five-cycle runs back to back.
    tag = "h1";
    if1.start = 1'b1;
    for (int k = 0; k < 15; k++) begin
      int p;
      p = k % 5;
      @(posedge clk); #1;
      chk($sformatf("busy@%0d", k), 4'(if1.busy), (p < 4) ? 4'd1 : 4'd0);
      chk($sformatf("done@%0d", k), 4'(if1.done), (p == 4) ? 4'd1 : 4'd0);
      chk($sformatf("idx@%0d", k),  4'(if1.vec_idx), (p < 4) ? 4'(p) : 4'd0);
      chk($sformatf("ab@%0d", k),   4'({if1.a, if1.b}), (p < 4) ? 4'(p) : 4'd0);
      if (p == 4) chk($sformatf("pass@%0d", k), 4'(if1.pass), 4'd1);
      if (p == 0) chk($sformatf("pass_clr@%0d", k), 4'(if1.pass), 4'd0);
      chk($sformatf("err@%0d", k), 4'(if1.err_count), 4'd0);
      @(negedge clk);
    end
    if1.start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
